// File: rtl/mic_i2s_receiver.sv
// mic_i2s_receiver: captures a Philips I2S microphone stream in the mon_clk domain,
// pairs left/right words and queues them in a small first-word-fall-through FIFO.
`timescale 1ns/1ps
module mic_i2s_receiver #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned FIFO_AW  = 2
) (
  input  logic                    mon_clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    mic_bclk,
  input  logic                    mic_lrck,
  input  logic                    mic_data,
  output logic [2*SAMPLE_W-1:0]   sample_data,
  output logic                    sample_valid,
  input  logic                    sample_ack,
  output logic [FIFO_AW:0]        sample_count,
  output logic                    overflow,
  output logic                    frame_error
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = $clog2(SAMPLE_W + 2);
  localparam logic [CW-1:0]    CNT_W     = CW'(SAMPLE_W);
  localparam logic [CW-1:0]    CNT_SAT   = CW'(SAMPLE_W + 1);
  localparam logic [CW-1:0]    CNT_SHORT = CW'(SAMPLE_W - 1);
  localparam logic [FIFO_AW:0] CNT_FULL  = (FIFO_AW+1)'(DEPTH);

  logic [2:0]             bclk_sync_q;
  logic [1:0]             lrck_sync_q, data_sync_q;
  logic                   bclk_rise, lin, din, keep;
  logic [SAMPLE_W-1:0]    shifted;

  logic [SAMPLE_W-1:0]    shift_q, shift_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   lrck_prev_q, lrck_prev_d;
  logic                   done_q, done_d;
  logic [SAMPLE_W-1:0]    done_word_q, done_word_d;
  logic                   done_right_q, done_right_d;
  logic                   done_short_q, done_short_d;

  logic                   synced_q, synced_d;
  logic                   lvalid_q, lvalid_d;
  logic [SAMPLE_W-1:0]    lhold_q, lhold_d;
  logic                   push_q, push_d;
  logic [2*SAMPLE_W-1:0]  push_word_q, push_word_d;
  logic                   ferr_q, ferr_d;

  logic [2*SAMPLE_W-1:0]  mem_q [DEPTH];
  logic [FIFO_AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]       count_q;
  logic                   ovf_q;
  logic                   pop, full, wr_en;

  always_ff @(posedge mon_clk or posedge rst) begin
    if (rst) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      data_sync_q <= '0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[1:0], mic_bclk};
      lrck_sync_q <= {lrck_sync_q[0], mic_lrck};
      data_sync_q <= {data_sync_q[0], mic_data};
    end
  end

  assign bclk_rise = bclk_sync_q[1] & ~bclk_sync_q[2];
  assign lin       = lrck_sync_q[1];
  assign din       = data_sync_q[1];
  assign shifted   = {shift_q[SAMPLE_W-2:0], din};
  assign keep      = (cnt_q < CNT_W);

  // An lrck change marks the final (one-bit-delayed) bit of the previous slot.
  always_comb begin
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    lrck_prev_d  = lrck_prev_q;
    done_d       = 1'b0;
    done_word_d  = done_word_q;
    done_right_d = done_right_q;
    done_short_d = done_short_q;
    if (!enable) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (bclk_rise) begin
      if (lin == lrck_prev_q) begin
        if (keep) shift_d = shifted;
        if (cnt_q != CNT_SAT) cnt_d = cnt_q + CW'(1);
      end else begin
        done_d       = 1'b1;
        done_word_d  = keep ? shifted : shift_q;
        done_right_d = lrck_prev_q;
        done_short_d = (cnt_q < CNT_SHORT);
        shift_d      = '0;
        cnt_d        = '0;
        lrck_prev_d  = lin;
      end
    end
  end

  always_ff @(posedge mon_clk or posedge rst) begin
    if (rst) begin
      shift_q      <= '0;
      cnt_q        <= '0;
      lrck_prev_q  <= 1'b0;
      done_q       <= 1'b0;
      done_word_q  <= '0;
      done_right_q <= 1'b0;
      done_short_q <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      lrck_prev_q  <= lrck_prev_d;
      done_q       <= done_d;
      done_word_q  <= done_word_d;
      done_right_q <= done_right_d;
      done_short_q <= done_short_d;
    end
  end

  always_comb begin
    synced_d    = synced_q;
    lvalid_d    = lvalid_q;
    lhold_d     = lhold_q;
    push_d      = 1'b0;
    push_word_d = push_word_q;
    ferr_d      = 1'b0;
    if (!enable) begin
      synced_d = 1'b0;
      lvalid_d = 1'b0;
    end else if (done_q) begin
      if (!synced_q) begin
        synced_d = 1'b1;
      end else if (done_short_q) begin
        ferr_d   = 1'b1;
        lvalid_d = 1'b0;
      end else if (!done_right_q) begin
        lhold_d  = done_word_q;
        lvalid_d = 1'b1;
      end else if (lvalid_q) begin
        push_d      = 1'b1;
        push_word_d = {lhold_q, done_word_q};
        lvalid_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge mon_clk or posedge rst) begin
    if (rst) begin
      synced_q    <= 1'b0;
      lvalid_q    <= 1'b0;
      lhold_q     <= '0;
      push_q      <= 1'b0;
      push_word_q <= '0;
      ferr_q      <= 1'b0;
    end else begin
      synced_q    <= synced_d;
      lvalid_q    <= lvalid_d;
      lhold_q     <= lhold_d;
      push_q      <= push_d;
      push_word_q <= push_word_d;
      ferr_q      <= ferr_d;
    end
  end

  assign pop   = sample_ack && (count_q != '0);
  assign full  = (count_q == CNT_FULL);
  assign wr_en = push_q && (!full || pop);

  always_ff @(posedge mon_clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (!enable) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= push_word_q;
        wr_ptr_q        <= wr_ptr_q + FIFO_AW'(1);
      end
      if (push_q && !wr_en) ovf_q <= 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      if (wr_en && !pop)      count_q <= count_q + (FIFO_AW+1)'(1);
      else if (pop && !wr_en) count_q <= count_q - (FIFO_AW+1)'(1);
    end
  end

  assign sample_data  = mem_q[rd_ptr_q];
  assign sample_valid = (count_q != '0);
  assign sample_count = count_q;
  assign overflow     = ovf_q;
  assign frame_error  = ferr_q;

endmodule

// File: tb/tb_mic_i2s_receiver.sv
// Testbench for mic_i2s_receiver: drives Philips I2S streams built from slot lists and
// checks FIFO contents, flags and latency against a slot-level reference model.
`timescale 1ns/1ps
module tb_mic_i2s_receiver;
  localparam int SW    = 16;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          mon_clk = 0, rst = 1, enable = 0;
  logic          mic_bclk = 0, mic_lrck = 0, mic_data = 0, sample_ack = 0;
  logic [31:0]   sample_data;
  logic          sample_valid, overflow, frame_error;
  logic [AW:0]   sample_count;

  int total = 0, bad = 0;

  mic_i2s_receiver #(.SAMPLE_W(SW), .FIFO_AW(AW)) dut (
    .mon_clk(mon_clk), .rst(rst), .enable(enable),
    .mic_bclk(mic_bclk), .mic_lrck(mic_lrck), .mic_data(mic_data),
    .sample_data(sample_data), .sample_valid(sample_valid), .sample_ack(sample_ack),
    .sample_count(sample_count), .overflow(overflow), .frame_error(frame_error)
  );

  always #100 mon_clk = ~mon_clk;

  int cyc = 0;
  int fe_cnt = 0;
  int valid_cyc = -1;
  bit vprev = 0;
  int rise_cyc [1024];

  always @(posedge mon_clk) cyc++;
  always @(posedge mon_clk) begin
    #1;
    if (frame_error === 1'b1) fe_cnt++;
    if (sample_valid === 1'b1 && !vprev && valid_cyc < 0) valid_cyc = cyc;
    vprev = (sample_valid === 1'b1);
  end

  // Reference model: collects the bits of each slot, judges the slot when lrck changes.
  bit          m_prev, m_synced, m_lvalid, m_ovf;
  logic [15:0] m_lhold;
  bit          m_slot [$];
  logic [31:0] m_fifo [$];
  int          m_fe = 0;

  function automatic void model_clear(bit full_reset);
    m_fifo.delete(); m_slot.delete();
    m_ovf = 0; m_synced = 0; m_lvalid = 0;
    if (full_reset) begin m_prev = 0; m_lhold = '0; end
  endfunction

  function automatic void model_rise(bit l, bit d);
    logic [15:0] w;
    int n;
    bit last;
    m_slot.push_back(d);
    if (l == m_prev) return;
    n = m_slot.size();
    w = '0;
    for (int j = 0; j < SW && j < n; j++) w = {w[14:0], m_slot[j]};
    m_slot.delete();
    last = m_prev;
    m_prev = l;
    if (!m_synced) m_synced = 1;
    else if (n < SW) begin m_fe++; m_lvalid = 0; end
    else if (!last) begin m_lhold = w; m_lvalid = 1; end
    else if (m_lvalid) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back({m_lhold, w});
      else m_ovf = 1;
      m_lvalid = 0;
    end
  endfunction

  bit q_lab [$], q_dat [$];

  function automatic void clear_stream();
    q_lab.delete(); q_dat.delete();
  endfunction

  function automatic void add_slot(bit lr, logic [31:0] w, int nbits);
    for (int j = nbits - 1; j >= 0; j--) begin q_lab.push_back(lr); q_dat.push_back(w[j]); end
  endfunction

  function automatic void add_frame(logic [31:0] l, logic [31:0] r, int nbits);
    add_slot(0, l, nbits); add_slot(1, r, nbits);
  endfunction

  // Period i carries data bit i; lrck already shows the owner of bit i+1 (one-bit delay).
  task automatic tx_run(input int from, input int to, input int ack_at);
    int n;
    int half;
    bit l;
    n = q_lab.size();
    for (int i = from; i < to; i++) begin
      half = $urandom_range(6, 8);
      l = (i + 1 < n) ? q_lab[i+1] : !q_lab[n-1];
      @(negedge mon_clk);
      mic_bclk = 0; mic_lrck = l; mic_data = q_dat[i];
      repeat (half - 1) @(negedge mon_clk);
      mic_bclk = 1;
      @(posedge mon_clk); #1;
      rise_cyc[i] = cyc;
      if (i == ack_at && m_fifo.size() > 0) void'(m_fifo.pop_front());
      model_rise(l, q_dat[i]);
      for (int k = 1; k < half; k++) begin
        @(negedge mon_clk);
        if (i == ack_at && k == 4) sample_ack = 1;
        if (i == ack_at && k == 5) sample_ack = 0;
      end
    end
    @(negedge mon_clk) mic_bclk = 0;
  endtask

  task automatic settle();
    repeat (10) @(negedge mon_clk);
  endtask

  task automatic pop_one();
    @(negedge mon_clk) sample_ack = 1;
    @(negedge mon_clk) sample_ack = 0;
    void'(m_fifo.pop_front());
  endtask

  task automatic test_reset();
    repeat (3) @(negedge mon_clk);
    total++; if (sample_data !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", sample_data); end
    total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", sample_valid); end
    total++; if (sample_count !== '0) begin bad++; $display("FAIL reset_count: got %0d want 0", sample_count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    total++; if (frame_error !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b want 0", frame_error); end
    rst = 0; enable = 1;
    model_clear(1);
  endtask

  task automatic test_basic();
    clear_stream();
    repeat (3) add_frame(32'h1234, 32'hABCD, 16);
    valid_cyc = -1;
    tx_run(0, q_lab.size(), -1);
    settle();
    total++; if (sample_count !== 3'(m_fifo.size())) begin bad++; $display("FAIL basic_count: got %0d want %0d", sample_count, m_fifo.size()); end
    total++; if (valid_cyc - rise_cyc[63] !== 4) begin bad++; $display("FAIL basic_latency: got %0d want 4", valid_cyc - rise_cyc[63]); end
    total++; if (fe_cnt !== m_fe) begin bad++; $display("FAIL basic_ferr: got %0d want %0d", fe_cnt, m_fe); end
    while (m_fifo.size() > 0) begin
      total++; if (sample_data !== m_fifo[0]) begin bad++; $display("FAIL basic_word: got %h want %h", sample_data, m_fifo[0]); end
      pop_one();
    end
  endtask

  task automatic test_long_frames();
    clear_stream();
    repeat (2) add_frame(32'hA5A5_FFFF, 32'h5A5A_0000, 32);
    add_frame($urandom, $urandom, 32);
    tx_run(0, q_lab.size(), -1);
    settle();
    total++; if (sample_count !== 3'(m_fifo.size())) begin bad++; $display("FAIL long_count: got %0d want %0d", sample_count, m_fifo.size()); end
    total++; if (fe_cnt !== m_fe) begin bad++; $display("FAIL long_ferr: got %0d want %0d", fe_cnt, m_fe); end
    while (m_fifo.size() > 0) begin
      total++; if (sample_data !== m_fifo[0]) begin bad++; $display("FAIL long_word: got %h want %h", sample_data, m_fifo[0]); end
      pop_one();
    end
  endtask

  task automatic test_short_slot();
    int fe0;
    fe0 = fe_cnt;
    clear_stream();
    add_slot(0, $urandom, 16);
    add_slot(1, $urandom, 8);
    add_frame(32'h0001, 32'h0002, 16);
    tx_run(0, q_lab.size(), -1);
    settle();
    total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL short_ferr: got %0d pulses want 1", fe_cnt - fe0); end
    total++; if (sample_count !== 3'(m_fifo.size())) begin bad++; $display("FAIL short_count: got %0d want %0d", sample_count, m_fifo.size()); end
    while (m_fifo.size() > 0) begin
      total++; if (sample_data !== m_fifo[0]) begin bad++; $display("FAIL short_word: got %h want %h", sample_data, m_fifo[0]); end
      pop_one();
    end
  endtask

  task automatic test_overflow();
    @(negedge mon_clk) rst = 1;
    model_clear(1);
    @(negedge mon_clk) rst = 0;
    clear_stream();
    repeat (7) add_frame($urandom, $urandom, 16);
    tx_run(0, 6 * 32, -1);
    settle();
    total++; if (sample_count !== 3'(m_fifo.size())) begin bad++; $display("FAIL ovf_count: got %0d want %0d", sample_count, m_fifo.size()); end
    total++; if (overflow !== m_ovf) begin bad++; $display("FAIL ovf_flag: got %b want %b", overflow, m_ovf); end
    total++; if (sample_data !== m_fifo[0]) begin bad++; $display("FAIL ovf_head: got %h want %h", sample_data, m_fifo[0]); end
    tx_run(6 * 32, 7 * 32, 7 * 32 - 1);
    settle();
    total++; if (sample_count !== 3'(m_fifo.size())) begin bad++; $display("FAIL ovf_popcount: got %0d want %0d", sample_count, m_fifo.size()); end
    total++; if (overflow !== m_ovf) begin bad++; $display("FAIL ovf_sticky: got %b want %b", overflow, m_ovf); end
    while (m_fifo.size() > 0) begin
      total++; if (sample_data !== m_fifo[0]) begin bad++; $display("FAIL ovf_word: got %h want %h", sample_data, m_fifo[0]); end
      pop_one();
    end
  endtask

  task automatic test_enable_drop();
    clear_stream();
    repeat (6) add_frame($urandom, $urandom, 16);
    tx_run(0, 3 * 32 + 7, -1);
    settle();
    total++; if (sample_count !== 3'(m_fifo.size())) begin bad++; $display("FAIL en_count_pre: got %0d want %0d", sample_count, m_fifo.size()); end
    @(negedge mon_clk) enable = 0;
    @(posedge mon_clk); #1;
    model_clear(0);
    total++; if (sample_count !== '0) begin bad++; $display("FAIL en_count: got %0d want 0", sample_count); end
    total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL en_valid: got %b want 0", sample_valid); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL en_ovf: got %b want 0", overflow); end
    repeat (3) @(negedge mon_clk);
    enable = 1;
    tx_run(3 * 32 + 7, q_lab.size(), -1);
    settle();
    total++; if (sample_count !== 3'(m_fifo.size())) begin bad++; $display("FAIL en_count_post: got %0d want %0d", sample_count, m_fifo.size()); end
    while (m_fifo.size() > 0) begin
      total++; if (sample_data !== m_fifo[0]) begin bad++; $display("FAIL en_word: got %h want %h", sample_data, m_fifo[0]); end
      pop_one();
    end
  endtask

  task automatic test_reset_midframe();
    clear_stream();
    repeat (4) add_frame($urandom, $urandom, 16);
    tx_run(0, 32 + 7, -1);
    settle();
    total++; if (sample_count !== 3'(m_fifo.size())) begin bad++; $display("FAIL rstmid_pre: got %0d want %0d", sample_count, m_fifo.size()); end
    @(negedge mon_clk);
    mic_lrck = q_lab[32 + 8]; mic_data = q_dat[32 + 7];
    #30 rst = 1;
    #1;
    model_clear(1);
    total++; if (sample_data !== '0) begin bad++; $display("FAIL rstmid_data: got %h want 0", sample_data); end
    total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b want 0", sample_valid); end
    total++; if (sample_count !== '0) begin bad++; $display("FAIL rstmid_count: got %0d want 0", sample_count); end
    repeat (2) @(negedge mon_clk);
    rst = 0;
    tx_run(32 + 7, q_lab.size(), -1);
    settle();
    total++; if (sample_count !== 3'(m_fifo.size())) begin bad++; $display("FAIL rstmid_count_post: got %0d want %0d", sample_count, m_fifo.size()); end
    while (m_fifo.size() > 0) begin
      total++; if (sample_data !== m_fifo[0]) begin bad++; $display("FAIL rstmid_word: got %h want %h", sample_data, m_fifo[0]); end
      pop_one();
    end
  endtask

  task automatic test_random();
    clear_stream();
    repeat (6) begin
      add_slot(0, $urandom, $urandom_range(13, 20));
      add_slot(1, $urandom, $urandom_range(13, 20));
    end
    tx_run(0, q_lab.size(), -1);
    settle();
    total++; if (sample_count !== 3'(m_fifo.size())) begin bad++; $display("FAIL rand_count: got %0d want %0d", sample_count, m_fifo.size()); end
    total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rand_ovf: got %b want %b", overflow, m_ovf); end
    total++; if (fe_cnt !== m_fe) begin bad++; $display("FAIL rand_ferr: got %0d want %0d", fe_cnt, m_fe); end
    while (m_fifo.size() > 0) begin
      total++; if (sample_data !== m_fifo[0]) begin bad++; $display("FAIL rand_word: got %h want %h", sample_data, m_fifo[0]); end
      pop_one();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_long_frames();
    test_short_slot();
    test_overflow();
    test_enable_drop();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mic_i2s_receiver.md
Name: mic_i2s_receiver

Overview:
- Captures the microphone I2S stream (mic_bclk, mic_lrck, mic_data) in the mon_clk domain and deserialises it into 16-bit left/right words.
- Completed stereo pairs go into a small FIFO that the monitor-side sender drains one word per request.
- It is the receive-side counterpart of the speaker I2S transmitter and feeds recorded audio back toward the monitor link.

Parameters:
- SAMPLE_W, 16, bits captured per channel; MSB first.
- FIFO_AW, 2, FIFO address width; depth is 2^FIFO_AW stereo words.

Ports:
- mon_clk  in  1  system clock, ~5 MHz; the only clock.
- rst  in  1  reset; asynchronous, active-high.
- enable  in  1  recording enable; low flushes and idles the block.
- mic_bclk  in  1  I2S bit clock; asynchronous; must be at most mon_clk/6.
- mic_lrck  in  1  I2S word select; asynchronous; 0 = left, 1 = right.
- mic_data  in  1  I2S serial data; asynchronous.
- sample_data  out  2*SAMPLE_W  FIFO head, {left, right}.
- sample_valid  out  1  FIFO not empty.
- sample_ack  in  1  one-cycle pop strobe; ignored when sample_valid is 0.
- sample_count  out  FIFO_AW+1  FIFO occupancy.
- overflow  out  1  sticky: a stereo word was dropped because the FIFO was full.
- frame_error  out  1  one-cycle pulse when a channel slot ends with fewer than SAMPLE_W bits.

Behaviour:
- Reset values:
  - sample_data=0, sample_valid=0, sample_count=0, overflow=0, frame_error=0.
  - Synchronisers, shift register, bit counter, left holding register and synced flag all cleared.
- Input synchronisation:
  - mic_bclk, mic_lrck and mic_data each pass through two flip-flops.
  - A third bclk register detects the rising edge. Only rising edges are acted on.
- Bit handling on each detected bclk rise (Philips I2S, one-bit delay):
  - Sample synchronised lrck (L) and data (D) and compare with lrck_prev, the L value at the previous rise.
  - If L == lrck_prev: the bit is bit index cnt of the current slot. If cnt < SAMPLE_W, shift D in. Then cnt increments and saturates at SAMPLE_W+1.
  - If L != lrck_prev: D is the last bit of the slot belonging to lrck_prev. Shift it in if cnt < SAMPLE_W. The slot is then complete with cnt+1 bits. Reset cnt to 0 and set lrck_prev=L.
  - Bits beyond SAMPLE_W in a slot are dropped (truncation toward MSB).
- Slot completion:
  - If synced=0: discard the word and set synced=1. The first slot after reset or enable rise is always partial.
  - Else if bits received < SAMPLE_W: discard, pulse frame_error, and clear the left-valid flag.
  - Else if the slot was left: store the word in left_hold and set left-valid.
  - Else (right) with left-valid=1: push {left_hold, word} and clear left-valid.
  - Else (right) with left-valid=0: discard the right word; no push, no error.
- Latency: sample_valid (or the count increment) is visible exactly 4 mon_clk cycles after the first mon_clk edge that samples mic_bclk high on the right slot's final bit.
- FIFO:
  - First-word-fall-through; sample_data is always the head entry and holds its value while empty.
  - A pop on sample_ack with sample_valid=1 advances the head on the next edge.
  - Push and pop in the same cycle are both performed; the count is unchanged, including when full.
  - Push while full without a pop: drop the new word, set overflow, keep FIFO contents.
  - Pointers wrap modulo 2^FIFO_AW; count 0..2^FIFO_AW.
- enable low:
  - Synchronously flush the FIFO (count=0, sample_valid=0).
  - Clear overflow, synced, left-valid and cnt.
  - Ignore bclk edges.
  - Re-enable resynchronises on the next lrck transition.
- Asynchronous rst mid-frame: all state clears immediately. The first word after release is discarded as partial.

Test Plan:
- 32-bit frames (16 bclk per slot), bclk = mon_clk/8, enable=1; send L=0x1234, R=0xABCD for 3 frames. Required: the first partial frame is dropped, then two pushes of 0x1234ABCD; sample_valid rises 4 cycles after the R LSB bclk rise.
- 64-bit frames (32 bclk per slot), L=0xA5A5_FFFF, R=0x5A5A_0000. Required: 0xA5A55A5A pushed; extra bits ignored; frame_error never pulses.
- 8-bclk right slot injected after a valid left. Required: frame_error pulses once, no push; the next full frame L=0x0001, R=0x0002 pushes 0x00010002.
- FIFO_AW=2, sample_ack held 0 for 5 good frames. Required: count=4, overflow=1, head is frame 1; then ack asserted on the same cycle as the 6th push: count stays 4, no extra overflow.
- Drop enable mid-slot with 3 words queued. Required: next cycle count=0, sample_valid=0, overflow=0; after re-enable the first partial slot is discarded, and the first complete stereo pair after it is pushed.
- Assert rst during bit 7 of a left slot. Required: all outputs 0 immediately; after release, the first complete pair after the discarded partial slot is captured correctly.
